// File: rtl/light_spi_pkg.sv
// Shared constants for the light-sensor ADC reader: FSM encodings, default timing
// and thermometer thresholds (thermometer output is enabled with LIGHT_THERMO_EN).
package light_spi_pkg;

    localparam int DEF_CLK_DIV    = 25;
    localparam int DEF_FRAME_BITS = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        CS_SETUP = ST_CS_SETUP,
        SHIFT    = ST_SHIFT,
        CS_HOLD  = ST_CS_HOLD,
        DONE     = ST_DONE
    } state_e;

    // Bit i of the thermometer code is set once the raw level reaches 32*i+16.
    localparam logic [7:0] THERMO_TH [8] = '{8'd16, 8'd48, 8'd80, 8'd112,
                                             8'd144, 8'd176, 8'd208, 8'd240};

    function automatic logic [7:0] thermo_code(input logic [7:0] raw);
        logic [7:0] code;
        code = '0;
        for (int i = 0; i < 8; i++) begin
            code[i] = (raw >= THERMO_TH[i]);
        end
        return code;
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer for the SPI reader: ticks every CLK_DIV enabled cycles and
// alternates between rise and fall ticks; clear restarts both count and phase.
module spi_sclk_div #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          tick;

    assign tick      = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_tick = tick && !phase_q;
    assign fall_tick = tick && phase_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_q   <= '0;
                phase_q <= !phase_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/light_adc_spi_reader.sv
// SPI mode-0 master reading one light-sensor ADC frame and returning an 8-bit level.
// Define LIGHT_THERMO_EN to return the thermometer code of the level instead of the raw value.
module light_adc_spi_reader
    import light_spi_pkg::*;
#(
    parameter int                    CLK_DIV    = DEF_CLK_DIV,
    parameter int                    FRAME_BITS = DEF_FRAME_BITS,
    parameter logic [FRAME_BITS-1:0] CMD_WORD   = '0,
    parameter int                    DATA_LSB   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] led_data,
    output logic       spi_done,
    output logic [2:0] dbg_state
);

    localparam int BW  = $clog2(FRAME_BITS) + 1;
    localparam int RXW = DATA_LSB + 8;

    state_e              state_q, state_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          led_q, led_d;
    logic [FRAME_BITS-2:0] tx_q, tx_d;
    logic [RXW-1:0]      rx_q, rx_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [7:0]          raw_level, level;
    logic                div_en, div_clear, rise_tick, fall_tick;

    assign div_en    = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);
    // Setup uses the divider's first tick; clearing here lets SHIFT begin at a low phase.
    assign div_clear = !div_en || ((state_q == CS_SETUP) && rise_tick);

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (div_en),
        .clear    (div_clear),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    assign raw_level = rx_q[RXW-1:DATA_LSB];
`ifdef LIGHT_THERMO_EN
    assign level = thermo_code(raw_level);
`else
    assign level = raw_level;
`endif

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        led_d   = led_q;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    state_d = CS_SETUP;
                    mosi_d  = CMD_WORD[FRAME_BITS-1];
                    tx_d    = CMD_WORD[FRAME_BITS-2:0];
                    bit_d   = '0;
                end
            end
            CS_SETUP: begin
                if (rise_tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (rise_tick) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[RXW-2:0], miso};
                    bit_d  = bit_q + BW'(1);
                end
                if (fall_tick) begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[FRAME_BITS-3:0], 1'b0};
                    if (bit_q == BW'(FRAME_BITS)) begin
                        state_d = CS_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        mosi_d = tx_q[FRAME_BITS-2];
                    end
                end
            end
            CS_HOLD: begin
                if (rise_tick) begin
                    state_d = DONE;
                    led_d   = level;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cs_n_d = (state_d == IDLE) || (state_d == DONE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= 8'h00;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            led_q   <= led_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
        end
    end

    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign busy      = busy_q;
    assign spi_done  = done_q;
    assign led_data  = led_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_light_adc_spi_reader.sv
// Directed bench for light_adc_spi_reader with an ADC slave model driving miso.
module tb_light_adc_spi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        miso;
    logic        busy, sclk, cs_n, mosi, spi_done;
    logic [7:0]  led_data;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    light_adc_spi_reader #(
        .CLK_DIV   (2),
        .FRAME_BITS(16),
        .CMD_WORD  (16'h0800),
        .DATA_LSB  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .led_data (led_data),
        .spi_done (spi_done),
        .dbg_state(dbg_state)
    );

    // ADC slave: presents frame MSB first, next bit after each rising sclk.
    logic [15:0] tx_frame = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000;
    int          rises = 0;
    int          rises_base = 0;
    int          fr_idx;

    assign fr_idx = rises - rises_base;
    assign miso   = (fr_idx < 16) ? tx_frame[4'(15 - fr_idx)] : 1'b0;

    always @(posedge sclk) begin
        rises    = rises + 1;
        mosi_cap = {mosi_cap[14:0], mosi};
    end

    always @(negedge cs_n) rises_base = rises;

    int hi_run = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if (cs_n === 1'b1) begin
            hi_run = hi_run + 1;
        end else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_level(input logic [7:0] r);
`ifdef LIGHT_THERMO_EN
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) t[i] = (int'(r) >= 32 * i + 16);
        return t;
`else
        return r;
`endif
    endfunction

    int          n_done, done_at, rises_at;
    logic [7:0]  led_at;
    logic [15:0] mosi_at;

    // Start is high in the first period; afterwards high while n<=hold_to or n==pulse2.
    task automatic run(input logic [15:0] frame, input int hold_to, input int pulse2,
                       input int window);
        tx_frame = frame;
        n_done   = 0;
        done_at  = -1;
        led_at   = 8'h00;
        rises_at = 0;
        mosi_at  = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= window; n++) begin
            @(negedge clk);
            start = (n <= hold_to) || (n == pulse2);
            if (spi_done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin
                    done_at  = n;
                    led_at   = led_data;
                    rises_at = rises - rises_base;
                    mosi_at  = mosi_cap;
                end
            end
        end
    endtask

    task automatic count_idle_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (spi_done === 1'b1) cnt++;
        end
    endtask

    int  extra;
    logic [15:0] b2b_frames [3] = '{16'h0110, 16'h0EE0, 16'h0770};
    logic [7:0]  b2b_raw    [3] = '{8'h11, 8'hEE, 8'h77};

    initial begin
        // reset
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", spi_done, 0);
        check("rst_led", led_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // single read
        run(16'h0A50, 0, -1, 80);
        check("single_ndone", n_done, 1);
        check("single_lat", done_at, 69);
        check("single_led", led_at, exp_level(8'hA5));
        check("single_rises", rises_at, 16);
        check("single_mosi", mosi_at, 16'h0800);
        check("single_cs_idle", cs_n, 1);

        // start held through the whole frame including DONE
        run(16'h0230, 69, -1, 150);
        check("hold_ndone", n_done, 1);
        check("hold_lat", done_at, 69);
        check("hold_led", led_at, exp_level(8'h23));

        // extra pulse during SHIFT
        run(16'h0FF0, 0, 20, 150);
        check("pulse_shift_ndone", n_done, 1);
        check("pulse_shift_lat", done_at, 69);

        // start only in DONE is ignored
        run(16'h0A50, 0, 69, 69);
        check("done_pulse_lat", done_at, 69);
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_idle0", busy, 0);
        @(negedge clk);
        check("done_pulse_idle1", busy, 0);
        count_idle_dones(80, extra);
        check("done_pulse_none", extra, 0);
        check("done_pulse_cs", cs_n, 1);

        // reset mid-SHIFT at the 8th rising edge
        tx_frame = 16'h0330;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && fr_idx < 8; n++) @(negedge clk);
        check("mid_rise8_reached", fr_idx, 8);
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_cs_n", cs_n, 1);
        check("mid_sclk", sclk, 0);
        check("mid_busy", busy, 0);
        check("mid_led", led_data, 8'h00);
        check("mid_done", spi_done, 0);
        count_idle_dones(80, extra);
        check("mid_no_done", extra, 0);
        run(16'h0C30, 0, -1, 80);
        check("post_rst_ndone", n_done, 1);
        check("post_rst_lat", done_at, 69);
        check("post_rst_led", led_at, exp_level(8'hC3));
        check("post_rst_rises", rises_at, 16);

        // thermometer / raw conversion
        run(16'h0000, 0, -1, 80);
`ifdef LIGHT_THERMO_EN
        check("conv_00", led_at, 8'h00);
`else
        check("conv_00", led_at, 8'h00);
`endif
        run(16'h0500, 0, -1, 80);
`ifdef LIGHT_THERMO_EN
        check("conv_50", led_at, 8'h07);
`else
        check("conv_50", led_at, 8'h50);
`endif
        run(16'h0FF0, 0, -1, 80);
        check("conv_ff", led_at, 8'hFF);

        // back-to-back frames, each started in the IDLE cycle after DONE
        for (int f = 0; f < 3; f++) begin
            run(b2b_frames[f], 0, -1, 69);
            check("b2b_lat", done_at, 69);
            check("b2b_led", led_at, exp_level(b2b_raw[f]));
            if (f > 0) check("b2b_gap", last_gap, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
